// File: rtl/tour_pkg.sv
// tour_pkg: shared states, command opcodes, headings and one-hot move codes for the tour path
package tour_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [7:0] HDG_W = 8'h3F;

    // Named by the long leg first, then the short leg (e.g. N2W1 = two north, one west)
    localparam logic [7:0] MV_N2W1 = 8'h01;
    localparam logic [7:0] MV_N2E1 = 8'h02;
    localparam logic [7:0] MV_W2N1 = 8'h04;
    localparam logic [7:0] MV_W2S1 = 8'h08;
    localparam logic [7:0] MV_S2W1 = 8'h10;
    localparam logic [7:0] MV_S2E1 = 8'h20;
    localparam logic [7:0] MV_E2N1 = 8'h40;
    localparam logic [7:0] MV_E2S1 = 8'h80;

    function automatic logic [3:0] mag(input logic signed [2:0] v);
        return v[2] ? 4'(-v) : 4'(v);
    endfunction

    function automatic logic onehot8(input logic [7:0] m);
        return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// tour_move_decode: one-hot knight move to signed square offsets plus a validity flag
module tour_move_decode
    import tour_pkg::*;
(
    input  logic              [7:0] move_i,
    output logic signed       [2:0] dx_o,
    output logic signed       [2:0] dy_o,
    output logic                    onehot_ok_o
);

    assign onehot_ok_o = onehot8(move_i);

    // Offset table shared with the solver; anything not one-hot decodes to (0,0)
    always_comb begin
        dx_o = 3'sd0;
        dy_o = 3'sd0;
        case (move_i)
            MV_N2W1: begin dx_o = -3'sd1; dy_o =  3'sd2; end
            MV_N2E1: begin dx_o =  3'sd1; dy_o =  3'sd2; end
            MV_W2N1: begin dx_o = -3'sd2; dy_o =  3'sd1; end
            MV_W2S1: begin dx_o = -3'sd2; dy_o = -3'sd1; end
            MV_S2W1: begin dx_o = -3'sd1; dy_o = -3'sd2; end
            MV_S2E1: begin dx_o =  3'sd1; dy_o = -3'sd2; end
            MV_E2N1: begin dx_o =  3'sd2; dy_o =  3'sd1; end
            MV_E2S1: begin dx_o =  3'sd2; dy_o = -3'sd1; end
            default: begin dx_o = 3'sd0; dy_o = 3'sd0; end
        endcase
    end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// tour_cmd_sequencer: walks the solved move table and issues a vertical then a horizontal command per move
module tour_cmd_sequencer
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  indx,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        resp_rdy,
    output logic        tour_done,
    output logic        move_err
);

    localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

    state_t             state_q, state_d;
    logic [4:0]         indx_q, indx_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [7:0]         move_q, move_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [7:0]         dec_in;
    logic signed [2:0]  dx, dy;
    logic               ok;
    logic [15:0]        vert_cmd, horz_cmd;

    // In LOAD the vertical leg is built from the live move; later the horizontal leg uses the latched copy
    assign dec_in = (state_q == LOAD) ? move : move_q;

    tour_move_decode u_dec (
        .move_i      (dec_in),
        .dx_o        (dx),
        .dy_o        (dy),
        .onehot_ok_o (ok)
    );

    assign vert_cmd  = {OP_MOVE,     dy[2] ? HDG_S : HDG_N, mag(dy)};
    assign horz_cmd  = {OP_MOVE_FAN, dx[2] ? HDG_W : HDG_E, mag(dx)};
    assign cmd_rdy   = (state_q == VERT) || (state_q == HORZ);
    assign indx      = indx_q;
    assign cmd       = cmd_q;
    assign tour_done = done_q;
    assign move_err  = err_q;

    // State and datapath registers; reset may strike at any point in a tour
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            indx_q  <= '0;
            cmd_q   <= '0;
            move_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            indx_q  <= indx_d;
            cmd_q   <= cmd_d;
            move_q  <= move_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Handshake sequencing: each leg waits for clr, then for a fresh resp in the following wait state
    always_comb begin
        state_d = state_q;
        indx_d  = indx_q;
        cmd_d   = cmd_q;
        move_d  = move_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start_tour) begin
                indx_d  = '0;
                state_d = LOAD;
            end
            LOAD: begin
                move_d = move;
                if (!ok) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cmd_d   = vert_cmd;
                    state_d = VERT;
                end
            end
            VERT: if (clr_cmd_rdy) state_d = WAIT_V;
            WAIT_V: if (resp_rdy) begin
                cmd_d   = horz_cmd;
                state_d = HORZ;
            end
            HORZ: if (clr_cmd_rdy) state_d = WAIT_H;
            WAIT_H: if (resp_rdy) begin
                if (indx_q == LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    indx_d  = indx_q + 5'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb_tour_cmd_sequencer: randomized tours against a move-table reference model with a command scoreboard
module tb_tour_cmd_sequencer;

    typedef struct {
        logic [15:0] c;
        logic [4:0]  i;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic        clr_cmd_rdy = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  move;
    logic [4:0]  indx;
    logic [15:0] cmd;
    logic        cmd_rdy, tour_done, move_err;

    logic [7:0]  tm [32];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    logic        rdy_prev = 1'b0;
    logic [15:0] cmd_prev = '0;

    always #10 clk = ~clk;

    assign move = tm[indx];

    tour_cmd_sequencer #(.NUM_MOVES(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_tour  (start_tour),
        .move        (move),
        .indx        (indx),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp_rdy    (resp_rdy),
        .tour_done   (tour_done),
        .move_err    (move_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: knight offsets straight from the move legend, legs formed by plain arithmetic
    function automatic logic [15:0] exp_cmd(input logic [7:0] m, input bit horz);
        int dxs [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
        int dys [8] = '{2, 2, 1, -1, -2, -2, 1, -1};
        int k = 0;
        int dx, dy;
        for (int b = 0; b < 8; b++) if (m[b]) k = b;
        dx = dxs[k];
        dy = dys[k];
        if (horz) return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
        return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    endfunction

    // Monitor: each new command offer is popped from the scoreboard; held commands must not change
    always @(negedge clk) begin
        if (!rst_n) begin
            rdy_prev <= 1'b0;
        end else begin
            if (cmd_rdy && !rdy_prev) begin
                check("cmd_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("cmd", cmd, mon_e.c);
                    check("indx", indx, mon_e.i);
                end
            end
            if (cmd_rdy && rdy_prev) check("cmd_stable", cmd, cmd_prev);
            if (tour_done) done_cnt++;
            rdy_prev <= cmd_rdy;
            cmd_prev <= cmd;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!cmd_rdy && n < 40) begin
            cyc();
            n++;
        end
        check("cmd_rdy_timeout", cmd_rdy, 1);
    endtask

    task automatic serve(input bit together);
        wait_rdy();
        repeat ($urandom_range(0, 2)) begin
            resp_rdy = 1'($urandom_range(0, 1));
            cyc();
        end
        clr_cmd_rdy = 1'b1;
        resp_rdy = together;
        cyc();
        clr_cmd_rdy = 1'b0;
        resp_rdy = 1'b0;
        check("clr_drops_rdy", cmd_rdy, 0);
        if (together) begin
            cyc();
            cyc();
            check("dual_stays_wait", cmd_rdy, 0);
        end
        repeat ($urandom_range(0, 3)) begin
            clr_cmd_rdy = 1'($urandom_range(0, 1));
            start_tour = ($urandom_range(0, 5) == 0);
            cyc();
        end
        clr_cmd_rdy = 1'b0;
        start_tour = 1'b0;
        resp_rdy = 1'b1;
        cyc();
        resp_rdy = 1'b0;
    endtask

    task automatic run_tour(input int err_at, input int abort_at);
        int n_ok = (err_at < 0) ? 24 : err_at;
        int d0 = done_cnt;
        for (int i = 0; i < n_ok; i++) begin
            exp_q.push_back('{c: exp_cmd(tm[i], 0), i: 5'(i)});
            exp_q.push_back('{c: exp_cmd(tm[i], 1), i: 5'(i)});
        end
        start_tour = 1'b1;
        cyc();
        start_tour = 1'b0;
        cyc();
        if (err_at == 0) begin
            check("err_set", move_err, 1);
            check("err_no_rdy", cmd_rdy, 0);
        end else begin
            check("start_latency_rdy", cmd_rdy, 1);
            check("first_cmd", cmd, exp_cmd(tm[0], 0));
        end
        for (int i = 0; i < n_ok; i++) begin
            serve($urandom_range(0, 3) == 0);
            if (i == abort_at) begin
                wait_rdy();
                check("abort_indx", indx, 5'(i));
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
                check("rst_indx", indx, 0);
                check("rst_cmd", cmd, 0);
                check("rst_cmd_rdy", cmd_rdy, 0);
                check("rst_move_err", move_err, 0);
                repeat (3) cyc();
                check("rst_idle", cmd_rdy, 0);
                exp_q.delete();
                return;
            end
            serve(1'b0);
        end
        if (err_at >= 0) begin
            if (err_at > 0) cyc();
            check("err_sticky_set", move_err, 1);
            repeat (3) cyc();
            check("err_idle_no_rdy", cmd_rdy, 0);
            check("err_indx_hold", indx, 5'(err_at));
            check("err_no_done", done_cnt - d0, 0);
        end else begin
            check("tour_done_pulse", tour_done, 1);
            check("done_indx", indx, 23);
            cyc();
            check("tour_done_clear", tour_done, 0);
            check("post_done_rdy", cmd_rdy, 0);
            check("done_count", done_cnt - d0, 1);
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic rand_table();
        for (int i = 0; i < 32; i++) tm[i] = 8'h01 << $urandom_range(0, 7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rand_table();
        cyc();
        cyc();
        check("reset_indx", indx, 0);
        check("reset_cmd", cmd, 0);
        check("reset_cmd_rdy", cmd_rdy, 0);
        check("reset_tour_done", tour_done, 0);
        check("reset_move_err", move_err, 0);
        rst_n = 1'b1;
        cyc();
        tm[0] = 8'h01;
        tm[1] = 8'h80;
        tm[2] = 8'h04;
        run_tour(-1, -1);
        repeat (3) begin
            rand_table();
            run_tour(-1, -1);
        end
        rand_table();
        run_tour(-1, 5);
        rand_table();
        run_tour(-1, -1);
        tm[0] = 8'h03;
        run_tour(0, -1);
        tm[0] = 8'h00;
        run_tour(0, -1);
        rand_table();
        run_tour(-1, -1);
        check("err_sticky_after_tour", move_err, 1);
        rand_table();
        tm[7] = 8'h81;
        run_tour(7, -1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("err_cleared_by_reset", move_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
